mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Issues loads and stores to the data memory over a req/gnt/rvalid handshake, resolves branches, and raises exceptions for overflow, misalignment and bus timeout.
- Stalls upstream while a memory access is outstanding and produces registered MEM/WB-side outputs for the write-back stage.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent in WAIT_GNT or WAIT_RSP before aborting with a bus error (counter is 8 bits).
- BUBBLE_ON_EXC, 1: 1 = an excepting instruction has RegWrite forced to 0.

Ports:
- clk  in  1  single clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- i_MEM_data_RTData  in  32  store data
- i_MEM_ctrl_MemWrite  in  1  store request
- i_MEM_ctrl_MemRead  in  1  load request
- i_MEM_ctrl_Branch  in  1  branch instruction
- i_WB_ctrl_Mem2Reg  in  1  write-back selects memory data
- i_WB_ctrl_RegWrite  in  1  write-back enable
- i_MEM_data_PCBranch  in  32  branch target
- i_MEM_data_ALUOut  in  32  ALU result / memory address
- i_MEM_data_Zero  in  1  ALU zero flag
- i_MEM_data_Overflow  in  1  ALU overflow flag
- i_WB_data_RegAddrW  in  32  destination register
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = store
- o_dmem_addr  out  32  word address (= ALUOut)
- o_dmem_wdata  out  32  store data
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  32  load data
- o_stall  out  1  hold EX/MEM and all upstream stages
- o_PCSrc  out  1  branch taken
- o_PCBranch  out  32  branch target passthrough
- o_WB_ctrl_Mem2Reg  out  1  registered
- o_WB_ctrl_RegWrite  out  1  registered
- o_WB_data_MemData  out  32  registered load data
- o_WB_data_ALUOut  out  32  registered ALU result
- o_WB_data_RegAddrW  out  32  registered destination register
- o_exc_Overflow  out  1  one-cycle pulse, aligned with WB outputs
- o_exc_Misalign  out  1  one-cycle pulse, aligned with WB outputs
- o_exc_BusErr  out  1  one-cycle pulse, aligned with WB outputs

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE, timeout counter=0, every registered output=0. o_dmem_req, o_stall and o_PCSrc evaluate to 0 because they are gated by the IDLE state and zero inputs.
- State machine, IDLE/WAIT_GNT/WAIT_RSP:
  - mem_op = MemRead | MemWrite. misalign = mem_op & (ALUOut[1:0] != 0).
  - If MemRead and MemWrite are both 1, the access is a store.
- IDLE:
  - If mem_op & ~misalign: o_dmem_req=1 combinationally, with we/addr/wdata taken from the inputs.
  - Store with gnt=1: completes this cycle, no stall.
  - Load with gnt=1: go to WAIT_RSP, o_stall=1.
  - gnt=0: go to WAIT_GNT, o_stall=1.
  - No memory op, or misaligned: completes this cycle, no request issued.
- WAIT_GNT: o_dmem_req=1 with stable we/addr/wdata.
  - gnt=1 on a store: go to IDLE; stall drops this cycle.
  - gnt=1 on a load: go to WAIT_RSP.
- WAIT_RSP: no request issued.
  - rvalid=1: capture rdata, go to IDLE; stall drops this cycle.
  - rvalid arriving while in IDLE is ignored.
- Timeout:
  - The counter increments in WAIT_GNT and WAIT_RSP and clears in IDLE.
  - When it reaches TIMEOUT_CYC: go to IDLE, drop the request, complete the instruction with o_exc_BusErr=1 and o_stall=0.
- Stall rule: o_stall = 1 whenever the instruction does not complete in the current cycle.
- Completion rule: the MEM/WB outputs load at the next rising edge after the completion cycle (1-cycle latency).
- Bubbles: on any non-completing cycle the edge loads a bubble: RegWrite=0, Mem2Reg=0, all exc=0, data fields hold their values.
- Exceptions: with BUBBLE_ON_EXC=1, Overflow, misalign or bus error forces RegWrite=0 at completion.
- Branch: o_PCSrc = Branch & Zero & ~o_stall (combinational). o_PCBranch = i_MEM_data_PCBranch.
- Timing: a zero-wait memory (gnt in the request cycle, rvalid one cycle later) gives a load 1 stall cycle and a store 0 stall cycles.
- Upstream contract: inputs are held stable by the upstream stages while o_stall=1.

Decomposition:
- Shared package mips_pkg: state encoding (IDLE=2'd0, WAIT_GNT=2'd1, WAIT_RSP=2'd2), TIMEOUT_CYC default, WORD_W=32.
- One natural sub-module: mem_wb_out_reg, holding the registered MEM/WB outputs with bubble-load and reset.
- The FSM and timeout counter live in the top module.

Test Plan:
- ALU op (RegWrite=1, ALUOut=0x1234, RegAddrW=5, no memory op) -> no req, stall=0; next edge o_WB_data_ALUOut=0x1234, RegWrite=1, RegAddrW=5.
- Load from 0x100, gnt in the same cycle, rvalid with 0xDEADBEEF two cycles later -> stall high 2 cycles; then MemData=0xDEADBEEF, Mem2Reg=1, RegWrite=1.
- Store of 0xA5A5A5A5 to 0x40, gnt delayed 3 cycles -> req/we/addr/wdata held stable 4 cycles; stall high 3 cycles; then RegWrite=0 at WB.
- Branch=1, Zero=1, PCBranch=0x2000 -> o_PCSrc=1 and o_PCBranch=0x2000 in the same cycle. Repeat with Zero=0 -> o_PCSrc=0.
- Load from 0x102 -> no req, stall=0; next edge o_exc_Misalign=1, RegWrite=0. Separately, Overflow=1 with RegWrite=1 -> o_exc_Overflow=1, RegWrite=0.
- Load with gnt=1 and rvalid never asserted -> after 255 WAIT_RSP cycles: stall drops, o_exc_BusErr=1.
- Reset asserted during WAIT_RSP -> all outputs 0 immediately; a late rvalid is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MEM-stage memory access unit.
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Bus handshake states of the memory access unit
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } mau_state_t;

    // A memory access must be word aligned; non-memory instructions never misalign
    function automatic logic is_misaligned(input logic memOp, input logic [1:0] addrLsb);
        return memOp && (addrLsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant/response bus between the MEM stage and the memory.
interface mem_access_unit_if;
    import mips_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [WORD_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_wb_out_reg.sv
// MEM/WB pipeline register: loads the completing instruction or a bubble each edge.
module mem_wb_out_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_complete,
    input  logic              i_loadData,
    input  logic              i_Mem2Reg,
    input  logic              i_RegWrite,
    input  logic [WORD_W-1:0] i_MemData,
    input  logic [WORD_W-1:0] i_ALUOut,
    input  logic [WORD_W-1:0] i_RegAddrW,
    input  logic              i_excOverflow,
    input  logic              i_excMisalign,
    input  logic              i_excBusErr,
    output logic              o_Mem2Reg,
    output logic              o_RegWrite,
    output logic [WORD_W-1:0] o_MemData,
    output logic [WORD_W-1:0] o_ALUOut,
    output logic [WORD_W-1:0] o_RegAddrW,
    output logic              o_excOverflow,
    output logic              o_excMisalign,
    output logic              o_excBusErr
);

    logic              r_Mem2Reg;
    logic              r_RegWrite;
    logic [WORD_W-1:0] r_MemData;
    logic [WORD_W-1:0] r_ALUOut;
    logic [WORD_W-1:0] r_RegAddrW;
    logic              r_excOverflow;
    logic              r_excMisalign;
    logic              r_excBusErr;

    // Control and exception flags: real values on completion, a bubble otherwise
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_Mem2Reg     <= 1'b0;
            r_RegWrite    <= 1'b0;
            r_excOverflow <= 1'b0;
            r_excMisalign <= 1'b0;
            r_excBusErr   <= 1'b0;
        end else if (i_complete) begin
            r_Mem2Reg     <= i_Mem2Reg;
            r_RegWrite    <= i_RegWrite;
            r_excOverflow <= i_excOverflow;
            r_excMisalign <= i_excMisalign;
            r_excBusErr   <= i_excBusErr;
        end else begin
            r_Mem2Reg     <= 1'b0;
            r_RegWrite    <= 1'b0;
            r_excOverflow <= 1'b0;
            r_excMisalign <= 1'b0;
            r_excBusErr   <= 1'b0;
        end
    end

    // Data fields only move on completion; load data only when a response arrived
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_MemData  <= '0;
            r_ALUOut   <= '0;
            r_RegAddrW <= '0;
        end else if (i_complete) begin
            r_ALUOut   <= i_ALUOut;
            r_RegAddrW <= i_RegAddrW;
            if (i_loadData) begin
                r_MemData <= i_MemData;
            end
        end
    end

    assign o_Mem2Reg     = r_Mem2Reg;
    assign o_RegWrite    = r_RegWrite;
    assign o_MemData     = r_MemData;
    assign o_ALUOut      = r_ALUOut;
    assign o_RegAddrW    = r_RegAddrW;
    assign o_excOverflow = r_excOverflow;
    assign o_excMisalign = r_excMisalign;
    assign o_excBusErr   = r_excBusErr;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory accesses, resolves branches, raises exceptions
// and stalls upstream until the current instruction completes.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
    parameter bit BUBBLE_ON_EXC = 1'b1
)
(
    input  logic              clk,
    input  logic              nrst,
    input  logic [WORD_W-1:0] i_MEM_data_RTData,
    input  logic              i_MEM_ctrl_MemWrite,
    input  logic              i_MEM_ctrl_MemRead,
    input  logic              i_MEM_ctrl_Branch,
    input  logic              i_WB_ctrl_Mem2Reg,
    input  logic              i_WB_ctrl_RegWrite,
    input  logic [WORD_W-1:0] i_MEM_data_PCBranch,
    input  logic [WORD_W-1:0] i_MEM_data_ALUOut,
    input  logic              i_MEM_data_Zero,
    input  logic              i_MEM_data_Overflow,
    input  logic [WORD_W-1:0] i_WB_data_RegAddrW,
    mem_access_unit_if.master dmem,
    output logic              o_stall,
    output logic              o_PCSrc,
    output logic [WORD_W-1:0] o_PCBranch,
    output logic              o_WB_ctrl_Mem2Reg,
    output logic              o_WB_ctrl_RegWrite,
    output logic [WORD_W-1:0] o_WB_data_MemData,
    output logic [WORD_W-1:0] o_WB_data_ALUOut,
    output logic [WORD_W-1:0] o_WB_data_RegAddrW,
    output logic              o_exc_Overflow,
    output logic              o_exc_Misalign,
    output logic              o_exc_BusErr
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

    mau_state_t r_state;
    mau_state_t w_nextState;
    logic [7:0] r_toCnt;

    logic w_memOp;
    logic w_misalign;
    logic w_isStore;
    logic w_timeout;
    logic w_req;
    logic w_complete;
    logic w_capture;
    logic w_busErr;
    logic w_excAny;
    logic w_regWrite;

    assign w_memOp    = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;
    assign w_misalign = is_misaligned(w_memOp, i_MEM_data_ALUOut[1:0]);
    assign w_isStore  = i_MEM_ctrl_MemWrite;
    assign w_timeout  = (r_toCnt == TO_LIMIT);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Bus timeout counter: runs across both wait states, cleared whenever idle or leaving
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_toCnt <= 8'd0;
        end else if (r_state == IDLE || w_nextState == IDLE) begin
            r_toCnt <= 8'd0;
        end else begin
            r_toCnt <= r_toCnt + 8'd1;
        end
    end

    // Next state, request and completion decode; a store with both flags set wins
    always_comb begin
        w_nextState = r_state;
        w_req       = 1'b0;
        w_complete  = 1'b0;
        w_capture   = 1'b0;
        w_busErr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_memOp && !w_misalign) begin
                    w_req = 1'b1;
                    if (dmem.gnt) begin
                        if (w_isStore) begin
                            w_complete = 1'b1;
                        end else begin
                            w_nextState = WAIT_RSP;
                        end
                    end else begin
                        w_nextState = WAIT_GNT;
                    end
                end else begin
                    w_complete = 1'b1;
                end
            end
            WAIT_GNT: begin
                if (w_timeout) begin
                    w_complete  = 1'b1;
                    w_busErr    = 1'b1;
                    w_nextState = IDLE;
                end else begin
                    w_req = 1'b1;
                    if (dmem.gnt) begin
                        if (w_isStore) begin
                            w_complete  = 1'b1;
                            w_nextState = IDLE;
                        end else begin
                            w_nextState = WAIT_RSP;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem.rvalid) begin
                    w_complete  = 1'b1;
                    w_capture   = 1'b1;
                    w_nextState = IDLE;
                end else if (w_timeout) begin
                    w_complete  = 1'b1;
                    w_busErr    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Request attributes come straight from EX/MEM, which upstream holds while stalled
    assign dmem.req   = w_req;
    assign dmem.we    = w_isStore;
    assign dmem.addr  = i_MEM_data_ALUOut;
    assign dmem.wdata = i_MEM_data_RTData;

    assign o_stall    = ~w_complete;
    assign o_PCSrc    = i_MEM_ctrl_Branch & i_MEM_data_Zero & w_complete;
    assign o_PCBranch = i_MEM_data_PCBranch;

    assign w_excAny   = i_MEM_data_Overflow | w_misalign | w_busErr;
    assign w_regWrite = i_WB_ctrl_RegWrite & ~(BUBBLE_ON_EXC & w_excAny);

    mem_wb_out_reg u_wbReg (
        .clk           (clk),
        .nrst          (nrst),
        .i_complete    (w_complete),
        .i_loadData    (w_capture),
        .i_Mem2Reg     (i_WB_ctrl_Mem2Reg),
        .i_RegWrite    (w_regWrite),
        .i_MemData     (dmem.rdata),
        .i_ALUOut      (i_MEM_data_ALUOut),
        .i_RegAddrW    (i_WB_data_RegAddrW),
        .i_excOverflow (i_MEM_data_Overflow),
        .i_excMisalign (w_misalign),
        .i_excBusErr   (w_busErr),
        .o_Mem2Reg     (o_WB_ctrl_Mem2Reg),
        .o_RegWrite    (o_WB_ctrl_RegWrite),
        .o_MemData     (o_WB_data_MemData),
        .o_ALUOut      (o_WB_data_ALUOut),
        .o_RegAddrW    (o_WB_data_RegAddrW),
        .o_excOverflow (o_exc_Overflow),
        .o_excMisalign (o_exc_Misalign),
        .o_excBusErr   (o_exc_BusErr)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions push their expected
// MEM/WB result; a monitor pops and compares on every completion the DUT signals.
module tb_mem_access_unit;
    import mips_pkg::*;

    typedef struct packed {
        logic        memWrite;
        logic        memRead;
        logic        branch;
        logic        zero;
        logic        overflow;
        logic        m2r;
        logic        rw;
        logic [31:0] rtData;
        logic [31:0] pcBranch;
        logic [31:0] aluOut;
        logic [31:0] regAddr;
    } instr_t;

    typedef struct packed {
        logic        m2r;
        logic        rw;
        logic [31:0] memData;
        logic [31:0] aluOut;
        logic [31:0] regAddr;
        logic        ov;
        logic        mis;
        logic        bus;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] i_MEM_data_RTData;
    logic        i_MEM_ctrl_MemWrite;
    logic        i_MEM_ctrl_MemRead;
    logic        i_MEM_ctrl_Branch;
    logic        i_WB_ctrl_Mem2Reg;
    logic        i_WB_ctrl_RegWrite;
    logic [31:0] i_MEM_data_PCBranch;
    logic [31:0] i_MEM_data_ALUOut;
    logic        i_MEM_data_Zero;
    logic        i_MEM_data_Overflow;
    logic [31:0] i_WB_data_RegAddrW;
    logic        o_stall;
    logic        o_PCSrc;
    logic [31:0] o_PCBranch;
    logic        o_WB_ctrl_Mem2Reg;
    logic        o_WB_ctrl_RegWrite;
    logic [31:0] o_WB_data_MemData;
    logic [31:0] o_WB_data_ALUOut;
    logic [31:0] o_WB_data_RegAddrW;
    logic        o_exc_Overflow;
    logic        o_exc_Misalign;
    logic        o_exc_BusErr;

    logic        instValid;
    int          checks;
    int          errors;
    exp_t        expQ[$];

    mem_access_unit_if dmemIf();

    mem_access_unit dut (
        .clk                 (clk),
        .nrst                (nrst),
        .i_MEM_data_RTData   (i_MEM_data_RTData),
        .i_MEM_ctrl_MemWrite (i_MEM_ctrl_MemWrite),
        .i_MEM_ctrl_MemRead  (i_MEM_ctrl_MemRead),
        .i_MEM_ctrl_Branch   (i_MEM_ctrl_Branch),
        .i_WB_ctrl_Mem2Reg   (i_WB_ctrl_Mem2Reg),
        .i_WB_ctrl_RegWrite  (i_WB_ctrl_RegWrite),
        .i_MEM_data_PCBranch (i_MEM_data_PCBranch),
        .i_MEM_data_ALUOut   (i_MEM_data_ALUOut),
        .i_MEM_data_Zero     (i_MEM_data_Zero),
        .i_MEM_data_Overflow (i_MEM_data_Overflow),
        .i_WB_data_RegAddrW  (i_WB_data_RegAddrW),
        .dmem                (dmemIf),
        .o_stall             (o_stall),
        .o_PCSrc             (o_PCSrc),
        .o_PCBranch          (o_PCBranch),
        .o_WB_ctrl_Mem2Reg   (o_WB_ctrl_Mem2Reg),
        .o_WB_ctrl_RegWrite  (o_WB_ctrl_RegWrite),
        .o_WB_data_MemData   (o_WB_data_MemData),
        .o_WB_data_ALUOut    (o_WB_data_ALUOut),
        .o_WB_data_RegAddrW  (o_WB_data_RegAddrW),
        .o_exc_Overflow      (o_exc_Overflow),
        .o_exc_Misalign      (o_exc_Misalign),
        .o_exc_BusErr        (o_exc_BusErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveIdle();
        i_MEM_data_RTData   = '0;
        i_MEM_ctrl_MemWrite = 1'b0;
        i_MEM_ctrl_MemRead  = 1'b0;
        i_MEM_ctrl_Branch   = 1'b0;
        i_WB_ctrl_Mem2Reg   = 1'b0;
        i_WB_ctrl_RegWrite  = 1'b0;
        i_MEM_data_PCBranch = '0;
        i_MEM_data_ALUOut   = '0;
        i_MEM_data_Zero     = 1'b0;
        i_MEM_data_Overflow = 1'b0;
        i_WB_data_RegAddrW  = '0;
        dmemIf.gnt          = 1'b0;
        dmemIf.rvalid       = 1'b0;
        dmemIf.rdata        = '0;
        instValid           = 1'b0;
    endtask

    task automatic driveInstr(input instr_t t);
        i_MEM_data_RTData   = t.rtData;
        i_MEM_ctrl_MemWrite = t.memWrite;
        i_MEM_ctrl_MemRead  = t.memRead;
        i_MEM_ctrl_Branch   = t.branch;
        i_WB_ctrl_Mem2Reg   = t.m2r;
        i_WB_ctrl_RegWrite  = t.rw;
        i_MEM_data_PCBranch = t.pcBranch;
        i_MEM_data_ALUOut   = t.aluOut;
        i_MEM_data_Zero     = t.zero;
        i_MEM_data_Overflow = t.overflow;
        i_WB_data_RegAddrW  = t.regAddr;
        instValid           = 1'b1;
    endtask

    // Single-cycle instruction: no request, no stall, branch outputs checked in-cycle
    task automatic applyStimulus(input instr_t t, input exp_t e, input logic expPCSrc, input string tag);
        @(posedge clk); #1;
        expQ.push_back(e);
        driveInstr(t);
        @(negedge clk);
        checkOutput({tag, "Req"}, 32'(dmemIf.req), 32'd0);
        checkOutput({tag, "Stall"}, 32'(o_stall), 32'd0);
        checkOutput({tag, "PCSrc"}, 32'(o_PCSrc), 32'(expPCSrc));
        checkOutput({tag, "PCBranch"}, o_PCBranch, t.pcBranch);
        @(posedge clk); #1;
        driveIdle();
    endtask

    // Memory instruction with gnt after gntDelay cycles and rvalid rspDelay cycles later
    // (rspDelay < 0 means the response never comes)
    task automatic runMemAccess(input instr_t t, input exp_t e, input int gntDelay, input int rspDelay,
                                input logic [31:0] rdata, input int expStall, input int expReqHeld,
                                input string tag);
        int  cyc;
        int  stallCyc;
        int  reqHeld;
        bit  done;
        logic rv;
        cyc      = 0;
        stallCyc = 0;
        reqHeld  = 0;
        done     = 1'b0;
        @(posedge clk); #1;
        expQ.push_back(e);
        driveInstr(t);
        while (!done && cyc < 600) begin
            rv = !t.memWrite && (rspDelay >= 0) && (cyc == gntDelay + rspDelay);
            dmemIf.gnt    = (cyc == gntDelay);
            dmemIf.rvalid = rv;
            dmemIf.rdata  = rv ? rdata : 32'h0;
            @(negedge clk);
            if (cyc <= gntDelay && dmemIf.req === 1'b1 && dmemIf.we === t.memWrite &&
                dmemIf.addr === t.aluOut && dmemIf.wdata === t.rtData) begin
                reqHeld++;
            end
            if (o_stall === 1'b1) begin
                stallCyc++;
            end else begin
                done = 1'b1;
            end
            cyc++;
            @(posedge clk); #1;
        end
        if (!done) begin
            checkOutput({tag, "CompletionBound"}, 32'd0, 32'd1);
        end
        driveIdle();
        checkOutput({tag, "StallCycles"}, 32'(stallCyc), 32'(expStall));
        checkOutput({tag, "ReqHeldCycles"}, 32'(reqHeld), 32'(expReqHeld));
    endtask

    // Monitor: compare WB outputs after each completing edge, and bubbles after stalled edges
    initial begin : monitor
        exp_t e;
        bit   pendCmp;
        bit   pendBub;
        pendCmp = 1'b0;
        pendBub = 1'b0;
        forever begin
            @(negedge clk);
            if (pendCmp) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedCompletion", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wbMem2Reg", 32'(o_WB_ctrl_Mem2Reg), 32'(e.m2r));
                    checkOutput("wbRegWrite", 32'(o_WB_ctrl_RegWrite), 32'(e.rw));
                    checkOutput("wbMemData", o_WB_data_MemData, e.memData);
                    checkOutput("wbALUOut", o_WB_data_ALUOut, e.aluOut);
                    checkOutput("wbRegAddrW", o_WB_data_RegAddrW, e.regAddr);
                    checkOutput("excOverflow", 32'(o_exc_Overflow), 32'(e.ov));
                    checkOutput("excMisalign", 32'(o_exc_Misalign), 32'(e.mis));
                    checkOutput("excBusErr", 32'(o_exc_BusErr), 32'(e.bus));
                end
            end
            if (pendBub) begin
                checkOutput("bubbleCtrl",
                            32'({o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite, o_exc_Overflow, o_exc_Misalign, o_exc_BusErr}),
                            32'd0);
            end
            pendCmp = instValid && (o_stall === 1'b0) && nrst;
            pendBub = instValid && (o_stall === 1'b1) && nrst;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, want finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        checks = 0;
        errors = 0;
        nrst   = 1'b0;
        driveIdle();

        // Reset state
        #12;
        checkOutput("rstReqStallPCSrc", 32'({dmemIf.req, o_stall, o_PCSrc}), 32'd0);
        checkOutput("rstWbCtrl",
                    32'({o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite, o_exc_Overflow, o_exc_Misalign, o_exc_BusErr}),
                    32'd0);
        checkOutput("rstMemData", o_WB_data_MemData, 32'd0);
        checkOutput("rstALUOut", o_WB_data_ALUOut, 32'd0);
        checkOutput("rstRegAddrW", o_WB_data_RegAddrW, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // ALU op
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1234, 32'd5},
                      '{1'b0, 1'b1, 32'h0, 32'h1234, 32'd5, 1'b0, 1'b0, 1'b0}, 1'b0, "alu");

        // Load, gnt in request cycle, rvalid two cycles later
        runMemAccess('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h100, 32'd7},
                     '{1'b1, 1'b1, 32'hDEADBEEF, 32'h100, 32'd7, 1'b0, 1'b0, 1'b0},
                     0, 2, 32'hDEADBEEF, 2, 1, "load");

        // Store, gnt delayed 3 cycles
        runMemAccess('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 32'h40, 32'd0},
                     '{1'b0, 1'b0, 32'hDEADBEEF, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0},
                     3, -1, 32'h0, 3, 4, "storeSlow");

        // Zero-wait store
        runMemAccess('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000011, 32'h0, 32'h44, 32'd0},
                     '{1'b0, 1'b0, 32'hDEADBEEF, 32'h44, 32'd0, 1'b0, 1'b0, 1'b0},
                     0, -1, 32'h0, 0, 1, "storeFast");

        // Branch taken / not taken
        applyStimulus('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2000, 32'h0, 32'd0},
                      '{1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0}, 1'b1, "brTaken");
        applyStimulus('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2000, 32'h0, 32'd0},
                      '{1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0}, 1'b0, "brNotTaken");

        // Misaligned load and overflow
        applyStimulus('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h102, 32'd9},
                      '{1'b1, 1'b0, 32'hDEADBEEF, 32'h102, 32'd9, 1'b0, 1'b1, 1'b0}, 1'b0, "misalign");
        applyStimulus('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h7, 32'd3},
                      '{1'b0, 1'b0, 32'hDEADBEEF, 32'h7, 32'd3, 1'b1, 1'b0, 1'b0}, 1'b0, "overflow");

        // Load whose response never arrives: 1 IDLE + 255 WAIT_RSP stalled cycles
        runMemAccess('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h104, 32'd10},
                     '{1'b1, 1'b0, 32'hDEADBEEF, 32'h104, 32'd10, 1'b0, 1'b0, 1'b1},
                     0, -1, 32'h0, 256, 1, "busTimeout");

        // Load with delayed gnt, then one-cycle response
        runMemAccess('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h108, 32'd12},
                     '{1'b1, 1'b1, 32'hCAFEF00D, 32'h108, 32'd12, 1'b0, 1'b0, 1'b0},
                     1, 1, 32'hCAFEF00D, 2, 2, "loadSlowGnt");

        // Reset asserted while waiting for a load response, then a late rvalid
        @(posedge clk); #1;
        driveInstr('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h200, 32'd4});
        dmemIf.gnt = 1'b1;
        @(posedge clk); #1;
        dmemIf.gnt = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b0;
        driveIdle();
        #1;
        checkOutput("midRstReqStallPCSrc", 32'({dmemIf.req, o_stall, o_PCSrc}), 32'd0);
        checkOutput("midRstWbCtrl",
                    32'({o_WB_ctrl_Mem2Reg, o_WB_ctrl_RegWrite, o_exc_Overflow, o_exc_Misalign, o_exc_BusErr}),
                    32'd0);
        checkOutput("midRstMemData", o_WB_data_MemData, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        dmemIf.rvalid = 1'b1;
        dmemIf.rdata  = 32'h12345678;
        @(posedge clk); #1;
        dmemIf.rvalid = 1'b0;
        dmemIf.rdata  = 32'h0;
        @(negedge clk);
        checkOutput("lateRvalidMemData", o_WB_data_MemData, 32'd0);
        checkOutput("lateRvalidStall", 32'(o_stall), 32'd0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
